// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between the instruction-fetch
// and load/store requesters of the RV32I core.
//   clk, rst                 : clock, synchronous active-high reset
//   i_read/i_addr            : instruction-side level request
//   i_rdata/i_resp           : instruction-side read data / completion
//   d_read/d_write/d_addr/
//   d_wdata/d_wmask          : data-side level request
//   d_rdata/d_resp           : data-side read data / completion
//   mem_*                    : shared memory port
//   proto_err, timeout_err   : sticky debug flags
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ARB_MODE   = 0,
   parameter int unsigned TIMEOUT    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_read,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   output logic                    i_resp,
   input  logic                    d_read,
   input  logic                    d_write,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wmask,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_resp,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_resp,
   output logic                    proto_err,
   output logic                    timeout_err
);

   localparam int unsigned CNT_WIDTH = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 last_d_q, last_d_d;   // 1: data side was served last
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 proto_err_d, timeout_err_d;
   logic                 d_req;

   assign d_req = d_read | d_write;

   // State and sticky-flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         cnt_q       <= '0;
         proto_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         cnt_q       <= cnt_d;
         proto_err   <= proto_err_d;
         timeout_err <= timeout_err_d;
      end
   end

   // Grant decision, port steering and watchdog
   always_comb begin
      state_d         = state_q;
      last_d_d        = last_d_q;
      cnt_d           = cnt_q;
      proto_err_d     = proto_err | (d_read & d_write);
      timeout_err_d   = timeout_err;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = i_addr;
      mem_wdata       = '0;
      mem_byte_enable = '0;
      i_resp          = 1'b0;
      d_resp          = 1'b0;
      i_rdata         = mem_rdata;
      d_rdata         = mem_rdata;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (i_read && d_req) begin
               // Round-robin hands the port to the side not served last
               state_d = (ARB_MODE == 0 || !last_d_q) ? D_BUSY : I_BUSY;
            end else if (d_req) begin
               state_d = D_BUSY;
            end else if (i_read) begin
               state_d = I_BUSY;
            end
         end
         I_BUSY: begin
            mem_read        = 1'b1;
            mem_byte_enable = '1;
            i_resp          = mem_resp;
            if (mem_resp) begin
               state_d  = IDLE;
               last_d_d = 1'b0;
            end
         end
         D_BUSY: begin
            // Simultaneous read and write is served as a write
            mem_read        = d_read & ~d_write;
            mem_write       = d_write;
            mem_address     = d_addr;
            mem_wdata       = d_wdata;
            mem_byte_enable = d_write ? d_wmask : '1;
            d_resp          = mem_resp;
            if (mem_resp) begin
               state_d  = IDLE;
               last_d_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Saturating wait counter; the arbiter keeps waiting after a timeout
      if (state_q != IDLE && !mem_resp) begin
         if (cnt_q != CNT_LIMIT) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
         if (TIMEOUT != 0 && cnt_d == CNT_LIMIT) begin
            timeout_err_d = 1'b1;
         end
      end

      // Reset squashes strobes and any memory response in the same cycle
      if (rst) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         i_resp    = 1'b0;
         d_resp    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (fixed priority with watchdog,
// round-robin without) checked against a transaction-level reference model,
// a directed vector table, a round-robin sequence and random traffic.
module tb_mem_port_arbiter;

   localparam int OWN_NONE = 0;
   localparam int OWN_I    = 1;
   localparam int OWN_D    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_read, d_read, d_write, mem_resp;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_wmask;

   logic [31:0] i_rdata0, d_rdata0, mem_address0, mem_wdata0;
   logic [31:0] i_rdata1, d_rdata1, mem_address1, mem_wdata1;
   logic [3:0]  mem_byte_enable0, mem_byte_enable1;
   logic        i_resp0, d_resp0, mem_read0, mem_write0, proto_err0, timeout_err0;
   logic        i_resp1, d_resp1, mem_read1, mem_write1, proto_err1, timeout_err1;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT(4)) dut0 (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata0), .i_resp(i_resp0),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wmask(d_wmask), .d_rdata(d_rdata0), .d_resp(d_resp0),
      .mem_read(mem_read0), .mem_write(mem_write0), .mem_address(mem_address0),
      .mem_wdata(mem_wdata0), .mem_byte_enable(mem_byte_enable0),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .proto_err(proto_err0), .timeout_err(timeout_err0)
   );

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT(0)) dut1 (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata1), .i_resp(i_resp1),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wmask(d_wmask), .d_rdata(d_rdata1), .d_resp(d_resp1),
      .mem_read(mem_read1), .mem_write(mem_write1), .mem_address(mem_address1),
      .mem_wdata(mem_wdata1), .mem_byte_enable(mem_byte_enable1),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .proto_err(proto_err1), .timeout_err(timeout_err1)
   );

   typedef struct packed {
      logic        mr, mw, ir, dr, pe, te;
      logic [3:0]  be;
      logic [31:0] addr, wdata, irdata, drdata;
   } obs_t;

   obs_t obs0, obs1;
   assign obs0 = '{mr: mem_read0, mw: mem_write0, ir: i_resp0, dr: d_resp0,
                   pe: proto_err0, te: timeout_err0, be: mem_byte_enable0,
                   addr: mem_address0, wdata: mem_wdata0, irdata: i_rdata0, drdata: d_rdata0};
   assign obs1 = '{mr: mem_read1, mw: mem_write1, ir: i_resp1, dr: d_resp1,
                   pe: proto_err1, te: timeout_err1, be: mem_byte_enable1,
                   addr: mem_address1, wdata: mem_wdata1, irdata: i_rdata1, drdata: d_rdata1};

   typedef struct {
      logic        rst, ir, dr, dw, resp;
      logic [31:0] ia, da, wd, rd;
      logic [3:0]  wm;
      logic        emr, emw, eir, edr, epe, ete;
      logic [3:0]  ebe;
      logic [31:0] eaddr, erd;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: who owns the port, who was served last, busy time, flags
   int m_owner[2];
   int m_last[2];
   int m_wait[2];
   bit m_pe[2];
   bit m_te[2];
   int m_mode[2] = '{0, 1};
   int m_tmo[2]  = '{4, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_owner[k] = OWN_NONE;
      m_last[k]  = OWN_I;
      m_wait[k]  = 0;
      m_pe[k]    = 1'b0;
      m_te[k]    = 1'b0;
   endtask

   task automatic model_check(input int k, input obs_t o);
      logic        emr, emw, eir, edr;
      logic [3:0]  ebe;
      logic [31:0] eaddr, ewd;
      bit          chk_wd;
      emr = 1'b0; emw = 1'b0; eir = 1'b0; edr = 1'b0;
      ebe = 4'h0; eaddr = i_addr; ewd = 32'h0; chk_wd = 1'b1;
      if (m_owner[k] == OWN_I) begin
         emr = !rst; ebe = 4'hF; eir = !rst && mem_resp; chk_wd = 1'b0;
      end else if (m_owner[k] == OWN_D) begin
         emw   = !rst && d_write;
         emr   = !rst && d_read && !d_write;
         eaddr = d_addr;
         ewd   = d_wdata;
         ebe   = d_write ? d_wmask : 4'hF;
         edr   = !rst && mem_resp;
      end
      chk($sformatf("dut%0d mem_read", k),  32'(o.mr), 32'(emr));
      chk($sformatf("dut%0d mem_write", k), 32'(o.mw), 32'(emw));
      chk($sformatf("dut%0d i_resp", k),    32'(o.ir), 32'(eir));
      chk($sformatf("dut%0d d_resp", k),    32'(o.dr), 32'(edr));
      chk($sformatf("dut%0d mem_address", k), o.addr, eaddr);
      chk($sformatf("dut%0d byte_enable", k), 32'(o.be), 32'(ebe));
      if (chk_wd) chk($sformatf("dut%0d mem_wdata", k), o.wdata, ewd);
      if (eir) chk($sformatf("dut%0d i_rdata", k), o.irdata, mem_rdata);
      if (edr) chk($sformatf("dut%0d d_rdata", k), o.drdata, mem_rdata);
      chk($sformatf("dut%0d proto_err", k),   32'(o.pe), 32'(m_pe[k]));
      chk($sformatf("dut%0d timeout_err", k), 32'(o.te), 32'(m_te[k]));
   endtask

   task automatic model_step(input int k);
      if (rst) begin
         model_reset(k);
         return;
      end
      if (d_read && d_write) m_pe[k] = 1'b1;
      if (m_owner[k] == OWN_NONE) begin
         m_wait[k] = 0;
         if (i_read && (d_read || d_write))
            m_owner[k] = (m_mode[k] == 0 || m_last[k] == OWN_I) ? OWN_D : OWN_I;
         else if (d_read || d_write)
            m_owner[k] = OWN_D;
         else if (i_read)
            m_owner[k] = OWN_I;
      end else if (mem_resp) begin
         m_last[k]  = m_owner[k];
         m_owner[k] = OWN_NONE;
      end else begin
         m_wait[k]++;
         if (m_tmo[k] != 0 && m_wait[k] >= m_tmo[k]) m_te[k] = 1'b1;
      end
   endtask

   // Apply one cycle of inputs and move to the sampling point
   task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] wm,
                        input logic rs, input logic [31:0] rdv);
      rst = r; i_read = ir; i_addr = ia; d_read = dr; d_write = dw;
      d_addr = da; d_wdata = wd; d_wmask = wm; mem_resp = rs; mem_rdata = rdv;
      #3;
   endtask

   task automatic cycle_end();
      model_check(0, obs0);
      model_check(1, obs1);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t row(
      input logic r, input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
      input logic [31:0] da, input logic [31:0] wd, input logic [3:0] wm,
      input logic rs, input logic [31:0] rdv,
      input logic emr, input logic emw, input logic [31:0] eaddr, input logic [3:0] ebe,
      input logic eir, input logic edr, input logic [31:0] erd,
      input logic epe, input logic ete);
      vec_t v;
      v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd;
      v.wm = wm; v.resp = rs; v.rd = rdv; v.emr = emr; v.emw = emw; v.eaddr = eaddr;
      v.ebe = ebe; v.eir = eir; v.edr = edr; v.erd = erd; v.epe = epe; v.ete = ete;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      // Directed table, expectations for dut0 (fixed priority, TIMEOUT=4)
      //                rst ir ia     dr dw da     wdata         wm    rs rdata       mr mw addr   be    ir dr rdata        pe te
      // lone fetch
      tbl.push_back(row(0, 1, 32'h60, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h60, 4'h0, 0, 0, 32'h0,      0, 0));
      tbl.push_back(row(0, 1, 32'h60, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      1, 0, 32'h60, 4'hF, 0, 0, 32'h0,      0, 0));
      tbl.push_back(row(0, 1, 32'h60, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      1, 0, 32'h60, 4'hF, 0, 0, 32'h0,      0, 0));
      tbl.push_back(row(0, 1, 32'h60, 0, 0, 32'h0, 32'h0,        4'h0, 1, 32'h13,     1, 0, 32'h60, 4'hF, 1, 0, 32'h13,     0, 0));
      tbl.push_back(row(0, 0, 32'h60, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h60, 4'h0, 0, 0, 32'h0,      0, 0));
      // contention, data side wins, then fetch is granted
      tbl.push_back(row(0, 1, 32'h64, 0, 1, 32'h100, 32'hDEADBEEF, 4'h3, 0, 32'h0,    0, 0, 32'h64, 4'h0, 0, 0, 32'h0,      0, 0));
      tbl.push_back(row(0, 1, 32'h64, 0, 1, 32'h100, 32'hDEADBEEF, 4'h3, 1, 32'h0,    0, 1, 32'h100, 4'h3, 0, 1, 32'h0,     0, 0));
      tbl.push_back(row(0, 1, 32'h64, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h64, 4'h0, 0, 0, 32'h0,      0, 0));
      tbl.push_back(row(0, 1, 32'h64, 0, 0, 32'h0, 32'h0,        4'h0, 1, 32'h11,     1, 0, 32'h64, 4'hF, 1, 0, 32'h11,     0, 0));
      tbl.push_back(row(0, 0, 32'h64, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h64, 4'h0, 0, 0, 32'h0,      0, 0));
      // protocol error: read and write together, served as write
      tbl.push_back(row(0, 0, 32'h64, 1, 1, 32'h200, 32'h55,     4'h1, 0, 32'h0,      0, 0, 32'h64, 4'h0, 0, 0, 32'h0,      0, 0));
      tbl.push_back(row(0, 0, 32'h64, 1, 1, 32'h200, 32'h55,     4'h1, 1, 32'h0,      0, 1, 32'h200, 4'h1, 0, 1, 32'h0,     1, 0));
      tbl.push_back(row(0, 0, 32'h64, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h64, 4'h0, 0, 0, 32'h0,      1, 0));
      tbl.push_back(row(0, 0, 32'h64, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h64, 4'h0, 0, 0, 32'h0,      1, 0));
      // timeout after 4 busy cycles, then normal completion
      tbl.push_back(row(0, 0, 32'h64, 1, 0, 32'h300, 32'h0,      4'h0, 0, 32'h0,      0, 0, 32'h64, 4'h0, 0, 0, 32'h0,      1, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(row(0, 0, 32'h64, 1, 0, 32'h300, 32'h0,   4'h0, 0, 32'h0,      1, 0, 32'h300, 4'hF, 0, 0, 32'h0,     1, 0));
      tbl.push_back(row(0, 0, 32'h64, 1, 0, 32'h300, 32'h0,      4'h0, 0, 32'h0,      1, 0, 32'h300, 4'hF, 0, 0, 32'h0,     1, 1));
      tbl.push_back(row(0, 0, 32'h64, 1, 0, 32'h300, 32'h0,      4'h0, 1, 32'hABCD,   1, 0, 32'h300, 4'hF, 0, 1, 32'hABCD,  1, 1));
      tbl.push_back(row(0, 0, 32'h64, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h64, 4'h0, 0, 0, 32'h0,      1, 1));
      // reset in the second fetch cycle, response dropped, then a data read
      tbl.push_back(row(0, 1, 32'h80, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h80, 4'h0, 0, 0, 32'h0,      1, 1));
      tbl.push_back(row(0, 1, 32'h80, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      1, 0, 32'h80, 4'hF, 0, 0, 32'h0,      1, 1));
      tbl.push_back(row(1, 1, 32'h80, 0, 0, 32'h0, 32'h0,        4'h0, 1, 32'h99,     0, 0, 32'h80, 4'hF, 0, 0, 32'h0,      1, 1));
      tbl.push_back(row(0, 0, 32'h80, 1, 0, 32'h400, 32'h0,      4'h0, 0, 32'h0,      0, 0, 32'h80, 4'h0, 0, 0, 32'h0,      0, 0));
      tbl.push_back(row(0, 0, 32'h80, 1, 0, 32'h400, 32'h0,      4'h0, 1, 32'h77,     1, 0, 32'h400, 4'hF, 0, 1, 32'h77,    0, 0));
      tbl.push_back(row(0, 0, 32'h80, 0, 0, 32'h0, 32'h0,        4'h0, 0, 32'h0,      0, 0, 32'h80, 4'h0, 0, 0, 32'h0,      0, 0));

      // Power-up reset
      rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset(0);
      model_reset(1);
      drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0);
      cycle_end();

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da,
               tbl[i].wd, tbl[i].wm, tbl[i].resp, tbl[i].rd);
         chk($sformatf("vec%0d mem_read", i),    32'(mem_read0),        32'(tbl[i].emr));
         chk($sformatf("vec%0d mem_write", i),   32'(mem_write0),       32'(tbl[i].emw));
         chk($sformatf("vec%0d mem_address", i), mem_address0,          tbl[i].eaddr);
         chk($sformatf("vec%0d byte_enable", i), 32'(mem_byte_enable0), 32'(tbl[i].ebe));
         chk($sformatf("vec%0d i_resp", i),      32'(i_resp0),          32'(tbl[i].eir));
         chk($sformatf("vec%0d d_resp", i),      32'(d_resp0),          32'(tbl[i].edr));
         if (tbl[i].eir) chk($sformatf("vec%0d i_rdata", i), i_rdata0, tbl[i].erd);
         if (tbl[i].edr) chk($sformatf("vec%0d d_rdata", i), d_rdata0, tbl[i].erd);
         chk($sformatf("vec%0d proto_err", i),   32'(proto_err0),       32'(tbl[i].epe));
         chk($sformatf("vec%0d timeout_err", i), 32'(timeout_err0),     32'(tbl[i].ete));
         cycle_end();
      end

      // Round-robin: last grant was D, both request -> I, then D
      drive(0, 1, 32'h90, 1, 0, 32'h500, 32'h0, 4'h0, 0, 32'h0);
      chk("rr idle mem_read", 32'(mem_read1), 32'(0));
      cycle_end();
      drive(0, 1, 32'h90, 1, 0, 32'h500, 32'h0, 4'h0, 1, 32'h1234);
      chk("rr first grant addr", mem_address1, 32'h90);
      chk("rr first i_resp", 32'(i_resp1), 32'(1));
      chk("rr first i_rdata", i_rdata1, 32'h1234);
      chk("fixed first grant addr", mem_address0, 32'h500);
      cycle_end();
      drive(0, 1, 32'h90, 1, 0, 32'h500, 32'h0, 4'h0, 0, 32'h0);
      chk("rr gap mem_read", 32'(mem_read1), 32'(0));
      cycle_end();
      drive(0, 1, 32'h90, 1, 0, 32'h500, 32'h0, 4'h0, 1, 32'h5678);
      chk("rr second grant addr", mem_address1, 32'h500);
      chk("rr second d_resp", 32'(d_resp1), 32'(1));
      chk("rr second i_resp", 32'(i_resp1), 32'(0));
      chk("fixed second grant addr", mem_address0, 32'h500);
      cycle_end();
      drive(0, 0, 32'h90, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
      cycle_end();

      // Random traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         drive(($urandom_range(0, 39) == 0),
               ($urandom_range(0, 3) != 0), $urandom,
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               $urandom, $urandom, 4'($urandom),
               ($urandom_range(0, 2) == 0), $urandom);
         cycle_end();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between the instruction-fetch requester and the load/store requester of the RV32I core. Both requesters use the same level handshake the multicycle control FSM uses: assert read/write, hold it until resp. The block grants one requester at a time, steers address/data/byte-enable to memory and routes resp/rdata back. It also flags protocol violations and memory-timeout events for debug.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
ARB_MODE, 0, 0 = fixed priority (data side wins), 1 = round-robin on last grant
TIMEOUT, 0, cycles allowed in a busy state before timeout_err sets; 0 disables the watchdog

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
i_read  in  1  instruction-side read request, level
i_addr  in  ADDR_WIDTH  instruction-side address
i_rdata  out  DATA_WIDTH  instruction read data, valid when i_resp=1
i_resp  out  1  instruction-side completion pulse
d_read  in  1  data-side read request, level
d_write  in  1  data-side write request, level
d_addr  in  ADDR_WIDTH  data-side address
d_wdata  in  DATA_WIDTH  data-side write data
d_wmask  in  DATA_WIDTH/8  data-side byte enables; a read forces all ones
d_rdata  out  DATA_WIDTH  data read data, valid when d_resp=1
d_resp  out  1  data-side completion pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_byte_enable  out  DATA_WIDTH/8  memory byte enables
mem_rdata  in  DATA_WIDTH  memory read data
mem_resp  in  1  memory completion, one cycle
proto_err  out  1  sticky: d_read and d_write were both seen high
timeout_err  out  1  sticky: TIMEOUT exceeded in a busy state

Behaviour:
- Reset values: state IDLE; last_grant = I; wait counter 0; proto_err 0; timeout_err 0.
- During any cycle with rst=1, mem_read, mem_write, i_resp and d_resp are forced to 0 combinationally.
- Requester rule: read/write, addr, wdata and wmask stay stable from assertion until the cycle resp=1. The requester may drop or change its request on the following cycle.
- States: IDLE, I_BUSY, D_BUSY.
- IDLE: strobes 0; mem_address = i_addr; mem_wdata = 0; mem_byte_enable = 0. Sample requests and transition:
  - only i_read -> I_BUSY
  - only d_read or d_write -> D_BUSY
  - both sides requesting, ARB_MODE=0 -> D_BUSY
  - both sides requesting, ARB_MODE=1 -> the side not equal to last_grant
  - none -> stay in IDLE
- Grant latency: the memory strobe asserts in the first busy cycle, one cycle after the request is first sampled in IDLE.
- I_BUSY: mem_read=1; mem_address=i_addr; byte_enable all ones; mem_write=0. i_rdata=mem_rdata. i_resp=mem_resp, same cycle, combinational.
- D_BUSY: mem_read=d_read&~d_write; mem_write=d_write; mem_address=d_addr; mem_wdata=d_wdata. byte_enable=d_wmask on writes, all ones on reads. d_rdata=mem_rdata. d_resp=mem_resp.
- The ungranted side's resp is always 0; its rdata is don't-care.
- Busy -> IDLE on the cycle mem_resp=1; last_grant is updated to the served side. The mandatory single IDLE cycle between transactions gives the requester time to drop or renew its request.
- Busy with mem_resp=0 stays busy. The grant is never preempted.
- A requester that drops its request while busy is a protocol violation. The arbiter keeps the strobes driven and waits for mem_resp.
- proto_err sets on any clock edge where d_read&d_write=1 while not in rst. The transaction is then served as a write.
- Watchdog: the counter clears on entering a busy state and increments each busy cycle without mem_resp. When TIMEOUT!=0 and the counter reaches TIMEOUT, timeout_err sets. The counter saturates and the arbiter keeps waiting.
- Sticky flags clear only on rst.
- Reset mid-transaction: next state is IDLE with all strobes 0. A mem_resp arriving in the rst cycle is dropped.
- Throughput: back-to-back single-side requests with 1-cycle memory complete every 3 cycles (IDLE, busy, resp-busy).

Test Plan:
- Lone fetch: i_read=1, i_addr=0x60 at cycle 0; mem_resp=1 with rdata=0x00000013 at cycle 3 -> mem_read=1/mem_address=0x60 on cycles 1-3; i_resp=1 and i_rdata=0x13 on cycle 3; IDLE on cycle 4; d_resp stays 0.
- Contention, ARB_MODE=0: i_read and d_write (addr 0x100, wdata 0xDEADBEEF, wmask 0x3) asserted together -> D_BUSY first with mem_write=1, be=0x3. After d_resp, I_BUSY is granted on the next IDLE decision.
- Contention, ARB_MODE=1, last_grant=D: both sides request -> I granted. After completion with both sides still requesting -> D granted.
- Protocol error: d_read=d_write=1 -> mem_write=1, mem_read=0, proto_err=1. proto_err holds after the requests drop; it clears only after rst.
- Timeout, TIMEOUT=4: d_read with mem_resp held 0 -> timeout_err=1 after 4 busy cycles. Arbiter stays in D_BUSY; a later mem_resp completes normally.
- Reset mid-op: assert rst in the 2nd I_BUSY cycle -> mem_read=0 that cycle; IDLE next cycle; flags 0; a new d_read is then granted normally.
